sprite_move_scheduler: RTL and testbench

Per-frame motion controller for the VGA sprite path. Once per frame, on entry to vertical blanking, it arbitrates between two player move requests (round-robin), applies one clamped step to the shared sprite position, and reports which player last moved. Its `posx`/`posy` feed the sprite address generator and its `player` feeds the renderer's colour select. Position therefore never changes while active pixels are being drawn.

---
 rtl/sprite_move_scheduler.sv | 145 ++++++++++++++
 tb/tb_sprite_move_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_move_scheduler.sv
// sprite_move_scheduler
//   Once per frame, on entry to vertical blanking, picks one of two player
//   move requests (round-robin) and applies a single clamped step to the
//   shared sprite position. The position only changes inside blanking, so
//   the sprite never tears while active pixels are drawn.
//
// Ports
//   clk, rst        : system clock, asynchronous active-high reset
//   pixelx, pixely  : scan position from the VGA timing block
//   req1/dir1       : player 1 move request (level) and direction
//   req2/dir2       : player 2 move request (level) and direction
//                     direction: 0 = up, 1 = down, 2 = left, 3 = right
//   posx, posy      : sprite top-left corner
//   player          : last granted player (0 = none yet, 1, 2)
//   grant1, grant2  : one-cycle pulse while that player's move is applied
module sprite_move_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 64,
  parameter int STEP     = 4,
  parameter int START_X  = 288,
  parameter int START_Y  = 208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixelx,
  input  logic [9:0] pixely,
  input  logic       req1,
  input  logic [1:0] dir1,
  input  logic       req2,
  input  logic [1:0] dir2,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic [1:0] player,
  output logic       grant1,
  output logic       grant2
);

  localparam logic [9:0]  V_BLANK = 10'(V_ACTIVE);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - SPRITE_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    MOVE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       blank_p0, blank_p1, frame_tick;
  logic [1:0] last;
  logic [1:0] win;
  logic [1:0] win_p1;
  logic [1:0] dir_p1;

  // The frame boundary is decided by the line number alone.
  logic unused_pixelx;
  assign unused_pixelx = ^pixelx;

  // Step toward zero, saturating at 0.
  function automatic logic [9:0] step_dec(input logic [9:0] cur);
    logic [10:0] wide;
    wide     = {1'b0, cur};
    step_dec = (wide < STEP_W) ? 10'd0 : 10'(wide - STEP_W);
  endfunction

  // Step away from zero, saturating at lim (11-bit intermediate so the
  // sum near the top of the 10-bit range cannot wrap).
  function automatic logic [9:0] step_inc(input logic [9:0] cur,
                                          input logic [10:0] lim);
    logic [10:0] sum;
    sum      = {1'b0, cur} + STEP_W;
    step_inc = (sum > lim) ? 10'(lim) : 10'(sum);
  endfunction

  // Round-robin winner from the live request lines; only acted on in ARB.
  always_comb begin
    win = 2'd0;
    if (req1 && req2) begin
      win = (last == 2'd1) ? 2'd2 : 2'd1;
    end else if (req1) begin
      win = 2'd1;
    end else if (req2) begin
      win = 2'd2;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick) state_nxt = ARB;
      ARB:     state_nxt = (win != 2'd0) ? MOVE : IDLE;
      MOVE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0/p1: blanking-entry edge detect, then control and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_p0   <= 1'b0;
      blank_p1   <= 1'b0;
      frame_tick <= 1'b0;
      state      <= IDLE;
      last       <= 2'd2;
      player     <= 2'd0;
      grant1     <= 1'b0;
      grant2     <= 1'b0;
      posx       <= 10'(START_X);
      posy       <= 10'(START_Y);
    end else begin
      blank_p0   <= (pixely == V_BLANK);
      blank_p1   <= blank_p0;
      frame_tick <= blank_p0 & ~blank_p1;
      state      <= state_nxt;
      grant1     <= 1'b0;
      grant2     <= 1'b0;
      if (state == ARB) begin
        grant1 <= (win == 2'd1);
        grant2 <= (win == 2'd2);
      end
      if (state == MOVE) begin
        player <= win_p1;
        last   <= win_p1;
        case (dir_p1)
          2'd0:    posy <= step_dec(posy);
          2'd1:    posy <= step_inc(posy, Y_MAX);
          2'd2:    posx <= step_dec(posx);
          default: posx <= step_inc(posx, X_MAX);
        endcase
      end
    end
  end

  // Stage p1: winner and its direction captured on leaving ARB.
  always_ff @(posedge clk) begin
    if (state == ARB) begin
      win_p1 <= win;
      dir_p1 <= (win == 2'd2) ? dir2 : dir1;
    end
  end

endmodule

// File: tb/tb_sprite_move_scheduler.sv
module tb_sprite_move_scheduler;

  localparam int STEP  = 4;
  localparam int X_LIM = 640 - 64;
  localparam int Y_LIM = 480 - 64;
  localparam int SX    = 288;
  localparam int SY    = 208;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pixelx, pixely;
  logic       req1, req2;
  logic [1:0] dir1, dir2;
  logic [9:0] posx, posy;
  logic [1:0] player;
  logic       grant1, grant2;

  sprite_move_scheduler dut (
    .clk(clk), .rst(rst), .pixelx(pixelx), .pixely(pixely),
    .req1(req1), .dir1(dir1), .req2(req2), .dir2(dir2),
    .posx(posx), .posy(posy), .player(player),
    .grant1(grant1), .grant2(grant2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int g;
    int x;
    int y;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gcount = 0;
  int   last_g = 0;
  // reference model state
  int   mx, my, mlast;
  // currently visible expected outputs
  int   vx, vy, vp;
  bit   pend = 0;
  exp_t pe;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mx = SX; my = SY; mlast = 2;
    vx = SX; vy = SY; vp = 0;
    q.delete();
  endtask

  // One frame's arbitration and step, expressed from the rules directly.
  task automatic model_frame(input int c);
    int   w, d;
    exp_t e;
    w = 0;
    if (req1 && req2) w = (mlast == 1) ? 2 : 1;
    else if (req1)    w = 1;
    else if (req2)    w = 2;
    if (w != 0) begin
      d = (w == 1) ? int'(dir1) : int'(dir2);
      case (d)
        0: my = (my - STEP < 0) ? 0 : my - STEP;
        1: my = (my + STEP > Y_LIM) ? Y_LIM : my + STEP;
        2: mx = (mx - STEP < 0) ? 0 : mx - STEP;
        default: mx = (mx + STEP > X_LIM) ? X_LIM : mx + STEP;
      endcase
      mlast = w;
      e.cyc = c + 4; e.g = w; e.x = mx; e.y = my;
      q.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard whenever a grant appears.
  always @(negedge clk) begin
    if (!rst) begin
      if (pend) begin
        chk("posx_after_grant", int'(posx), pe.x);
        chk("posy_after_grant", int'(posy), pe.y);
        chk("player_after_grant", int'(player), pe.g);
        vx = pe.x; vy = pe.y; vp = pe.g;
        pend = 0;
      end else begin
        chk("posx_steady", int'(posx), vx);
        chk("posy_steady", int'(posy), vy);
        chk("player_steady", int'(player), vp);
      end
      chk("grant_overlap", int'(grant1 & grant2), 0);
      if (grant1 || grant2) begin
        gcount++;
        if (q.size() == 0) begin
          chk("spurious_grant", int'(grant1) + 2 * int'(grant2), 0);
        end else begin
          pe = q.pop_front();
          chk("grant_cycle", cyc, pe.cyc);
          chk("grant_id", grant1 ? 1 : 2, pe.g);
          last_g = pe.g;
          pend = 1;
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        pe = q.pop_front();
        chk("missing_grant", 0, pe.g);
        vx = pe.x; vy = pe.y; vp = pe.g;
      end
    end
  end

  task automatic set_line(input int y, input int n);
    @(posedge clk); #2;
    if (y == 480 && pixely != 10'd480) model_frame(cyc);
    pixely = 10'(y);
    pixelx = 10'($urandom_range(0, 799));
    repeat (n - 1) begin @(posedge clk); #2; end
  endtask

  task automatic run_frame(input int per, input int hold,
                           input bit r1, input int d1,
                           input bit r2, input int d2, input bit pulse);
    set_line(100, 1);
    if (pulse) begin
      req1 = 1'b0; req2 = 1'b1; dir2 = 2'(d2);
      set_line(100, 10);
      req2 = 1'b0;
    end else begin
      req1 = r1; dir1 = 2'(d1); req2 = r2; dir2 = 2'(d2);
    end
    set_line(100, per);
    for (int y = 470; y < 480; y++) set_line(y, per);
    set_line(480, hold);
    for (int y = 481; y <= 490; y++) set_line(y, per);
    set_line(524, per);
    set_line(0, per);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_posx", int'(posx), SX);
    chk("rst_posy", int'(posy), SY);
    chk("rst_player", int'(player), 0);
    chk("rst_grants", int'(grant1) + int'(grant2), 0);
    model_reset();
    pend = 0;
    #1;
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    rst = 1'b1; pixely = 10'd0; pixelx = 10'd0;
    req1 = 1'b0; req2 = 1'b0; dir1 = 2'd0; dir2 = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // reset asserted mid-frame
    set_line(200, 5);
    do_reset();

    // single request, right
    g0 = gcount;
    run_frame(1, 1, 1'b1, 3, 1'b0, 0, 1'b0);
    chk("single_posx", int'(posx), 292);
    chk("single_player", int'(player), 1);
    chk("single_grants", gcount - g0, 1);

    // fairness, both requesting
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_frame(1, 1, 1'b1, 0, 1'b1, 1, 1'b0);
      chk("fair_winner", last_g, (i % 2 == 0) ? 1 : 2);
      chk("fair_posy", int'(posy), (i % 2 == 0) ? 204 : 208);
    end

    // request outside the sampling window
    g0 = gcount;
    run_frame(1, 1, 1'b0, 0, 1'b0, 0, 1'b1);
    chk("window_grants", gcount - g0, 0);
    chk("window_posy", int'(posy), 208);

    // clamps
    do_reset();
    repeat (72) run_frame(1, 1, 1'b1, 2, 1'b0, 0, 1'b0);
    chk("clamp_left_reach", int'(posx), 0);
    g0 = gcount;
    run_frame(1, 1, 1'b1, 2, 1'b0, 0, 1'b0);
    chk("clamp_left_posx", int'(posx), 0);
    chk("clamp_left_grant", gcount - g0, 1);
    repeat (144) run_frame(1, 1, 1'b1, 3, 1'b0, 0, 1'b0);
    chk("clamp_right_reach", int'(posx), 576);
    g0 = gcount;
    run_frame(1, 1, 1'b0, 0, 1'b1, 3, 1'b0);
    chk("clamp_right_posx", int'(posx), 576);
    chk("clamp_right_grant", gcount - g0, 1);
    repeat (52) run_frame(1, 1, 1'b1, 1, 1'b0, 0, 1'b0);
    chk("clamp_down_reach", int'(posy), 416);
    g0 = gcount;
    run_frame(1, 1, 1'b1, 1, 1'b0, 0, 1'b0);
    chk("clamp_down_posy", int'(posy), 416);
    chk("clamp_down_grant", gcount - g0, 1);

    // slow pixel clock, long blanking-entry line
    for (int i = 0; i < 3; i++) begin
      g0 = gcount;
      run_frame(2, 60, 1'b1, 0, 1'b1, 2, 1'b0);
      chk("slow_one_grant", gcount - g0, 1);
    end

    // randomized frames
    for (int i = 0; i < 120; i++) begin
      run_frame($urandom_range(1, 2), $urandom_range(1, 8),
                1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end

    // reset while the move is in flight (state ARB)
    run_frame(1, 1, 1'b0, 0, 1'b0, 0, 1'b0);
    req1 = 1'b1; dir1 = 2'd3; req2 = 1'b0;
    set_line(479, 2);
    set_line(480, 3);
    @(posedge clk); #2;
    pixely = 10'd481;
    rst = 1'b1;
    #1;
    chk("midflight_posx", int'(posx), SX);
    chk("midflight_player", int'(player), 0);
    chk("midflight_grants", int'(grant1) + int'(grant2), 0);
    model_reset();
    pend = 0;
    #1;
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b0;
    g0 = gcount;
    set_line(490, 10);
    chk("midflight_no_grant", gcount - g0, 0);
    chk("midflight_posx_after", int'(posx), SX);

    repeat (10) @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
